// File: rtl/parser_sched.sv
// Round-robin dispatch of one shared segment stream to NUM_PARSERS parsers, with in-order PHV collection.
// Latency: par_start to in_ready is HOLD_CYC+1 cycles; a parser's PHV reaches out_valid one cycle after par_valid.
// Backpressure: dispatch waits in IDLE while the next parser in turn is busy; par_stg_ready drops while out_valid waits on out_ready.
// Optional build macro PARSER_SCHED_STATS_EN adds the stat_pkts / stat_stall counters.
module parser_sched #(
    parameter int NUM_PARSERS = 2,
    parameter int PHV_W       = 2304,
    parameter int HOLD_CYC    = 2,
    parameter int IDX_W       = 1
) (
    input  logic                         axis_clk,
    input  logic                         areset,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_PARSERS-1:0]       par_start,
    output logic [NUM_PARSERS-1:0]       par_stg_ready,
    input  logic [NUM_PARSERS-1:0]       par_valid,
    input  logic [NUM_PARSERS*PHV_W-1:0] par_phv,
    output logic                         out_valid,
    output logic [PHV_W-1:0]             out_phv,
    input  logic                         out_ready,
    output logic                         err
`ifdef PARSER_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_pkts,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]         d_ptr_q, d_ptr_d;
    logic [IDX_W-1:0]         c_ptr_q, c_ptr_d;
    logic [NUM_PARSERS-1:0]   busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic [PHV_W-1:0]         out_phv_q, out_phv_d;
    logic                     err_q, err_d;

    logic                     disp_go;
    logic [NUM_PARSERS-1:0]   d_onehot;
    logic [NUM_PARSERS-1:0]   c_onehot;
    logic                     cap_go;
    logic                     bad_valid;
    logic [PHV_W-1:0]         cap_phv;

    // Strict round robin: only the parser at d_ptr may be started, never skipped.
    assign d_onehot = NUM_PARSERS'(1) << d_ptr_q;
    assign c_onehot = NUM_PARSERS'(1) << c_ptr_q;
    assign disp_go  = (state_q == S_IDLE) && in_valid && !busy_q[d_ptr_q];

    // Dispatch FSM state register: state, bus-hold counter and dispatch pointer.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            d_ptr_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            d_ptr_q    <= d_ptr_d;
        end
    end

    // Dispatch FSM next state: start, hold the segment bus HOLD_CYC cycles, then acknowledge upstream.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        d_ptr_d    = d_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (disp_go) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = CNT_W'(HOLD_CYC - 1);
                end
            end
            S_HOLD: begin
                // in_valid is not re-checked here: a drop mid-hold is an upstream fault we ride through.
                if (hold_cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                d_ptr_d = d_ptr_q + IDX_W'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dispatch FSM outputs: start pulse in the accepting IDLE cycle, in_ready only in ACK.
    always_comb begin
        in_ready  = (state_q == S_ACK);
        par_start = disp_go ? d_onehot : '0;
    end

    // Collect decode: accept only the parser in turn, while it is busy and the output slot is free.
    always_comb begin
        cap_go    = 1'b0;
        bad_valid = 1'b0;
        cap_phv   = '0;
        for (int k = 0; k < NUM_PARSERS; k++) begin
            par_stg_ready[k] = (IDX_W'(k) == c_ptr_q) && busy_q[k] && !out_valid_q;
            if (IDX_W'(k) == c_ptr_q) begin
                cap_phv = par_phv[k*PHV_W +: PHV_W];
            end
            if (par_valid[k]) begin
                if ((IDX_W'(k) == c_ptr_q) && busy_q[k] && !out_valid_q) begin
                    cap_go = 1'b1;
                end else begin
                    bad_valid = 1'b1;
                end
            end
        end
    end

    // Collect next state: a dispatch set and a collect clear always target different parsers.
    always_comb begin
        busy_d      = (busy_q | par_start) & ~(cap_go ? c_onehot : '0);
        c_ptr_d     = cap_go ? (c_ptr_q + IDX_W'(1)) : c_ptr_q;
        out_phv_d   = cap_go ? cap_phv : out_phv_q;
        out_valid_d = out_valid_q;
        if (cap_go) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A rejected PHV is simply dropped; only the sticky flag records it.
        err_d = err_q | bad_valid;
    end

    // Collect path registers: busy bitmap, collect pointer, output slot and sticky error.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            busy_q      <= '0;
            c_ptr_q     <= '0;
            out_valid_q <= 1'b0;
            out_phv_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            c_ptr_q     <= c_ptr_d;
            out_valid_q <= out_valid_d;
            out_phv_q   <= out_phv_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_phv   = out_phv_q;
    assign err       = err_q;

`ifdef PARSER_SCHED_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Statistics next state: packets acknowledged, and IDLE cycles blocked on a busy parser.
    always_comb begin
        stat_pkts_d  = stat_pkts_q + ((state_q == S_ACK) ? 32'd1 : 32'd0);
        stat_stall_d = stat_stall_q +
                       (((state_q == S_IDLE) && in_valid && busy_q[d_ptr_q]) ? 32'd1 : 32'd0);
    end

    // Statistics registers, free-running and wrapping at 2^32.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            stat_pkts_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_pkts_q  <= stat_pkts_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_parser_sched.sv
// Bench for parser_sched: directed vector table, hand-written corner sequences, and a
// randomized run checked against a transaction-level model of dispatch and collection.
`timescale 1ns/1ps
module tb_parser_sched;

    localparam int N  = 2;
    localparam int PW = 64;
    localparam int H  = 2;

    logic            clk = 1'b0;
    logic            areset;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    par_start;
    logic [N-1:0]    par_stg_ready;
    logic [N-1:0]    par_valid;
    logic [N*PW-1:0] par_phv;
    logic            out_valid;
    logic [PW-1:0]   out_phv;
    logic            out_ready;
    logic            err;
`ifdef PARSER_SCHED_STATS_EN
    logic [31:0]     stat_pkts;
    logic [31:0]     stat_stall;
`endif

    always #5 clk = ~clk;

    parser_sched #(
        .NUM_PARSERS(N),
        .PHV_W(PW),
        .HOLD_CYC(H),
        .IDX_W(1)
    ) dut (
        .axis_clk(clk),
        .areset(areset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .par_start(par_start),
        .par_stg_ready(par_stg_ready),
        .par_valid(par_valid),
        .par_phv(par_phv),
        .out_valid(out_valid),
        .out_phv(out_phv),
        .out_ready(out_ready),
        .err(err)
`ifdef PARSER_SCHED_STATS_EN
        ,
        .stat_pkts(stat_pkts),
        .stat_stall(stat_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] phv_of(input int unsigned tag);
        return {32'hA5A5_0000 ^ tag, ~tag};
    endfunction

    // ---------------- transaction-level reference model ----------------
    int            cyc, next_ok, ack_due, acc_cnt, col_cnt;
    int unsigned   tag_ctr, up_tag;
    bit            up_pend;
    bit            par_has [N];
    int unsigned   par_tag [N];
    int            done_cyc[N];
    bit            m_ov;
    logic [PW-1:0] m_phv;
    int unsigned   exp_q[$];
    int            start_log[$];
    logic [31:0]   m_pkts, m_stall;

    // knobs
    int k_in_pct, k_ordy_pct, k_ordy_low_until;
    int unsigned k_max_tags;
    int k_lat_lo[N];
    int k_lat_hi[N];

    task automatic model_reset();
        cyc = 0; next_ok = 0; ack_due = -1; acc_cnt = 0; col_cnt = 0;
        tag_ctr = 0; up_tag = 0; up_pend = 0;
        for (int k = 0; k < N; k++) begin
            par_has[k] = 0; par_tag[k] = 0; done_cyc[k] = 0;
        end
        m_ov = 0; m_phv = '0; m_pkts = '0; m_stall = '0;
        exp_q.delete(); start_log.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1; in_valid = 1'b0; par_valid = '0; par_phv = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        areset = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_par_start", 64'(par_start), 64'(0));
        chk("rst_stg_ready", 64'(par_stg_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_phv", 64'(out_phv), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
`ifdef PARSER_SCHED_STATS_EN
        chk("rst_stat_pkts", 64'(stat_pkts), 64'(0));
        chk("rst_stat_stall", 64'(stat_stall), 64'(0));
`endif
    endtask

    task automatic set_knobs(input int in_pct, input int ordy_pct, input int ordy_low_until,
                             input int unsigned max_tags, input int lo0, input int hi0,
                             input int lo1, input int hi1);
        k_in_pct = in_pct; k_ordy_pct = ordy_pct; k_ordy_low_until = ordy_low_until;
        k_max_tags = max_tags;
        k_lat_lo[0] = lo0; k_lat_hi[0] = hi0; k_lat_lo[1] = lo1; k_lat_hi[1] = hi1;
    endtask

    // Each iteration is one clock: drive, settle, compare against the model, advance the model.
    task automatic run(input int ncyc);
        int           cidx, didx;
        bit           go, exp_ir;
        logic [N-1:0] exp_stg, exp_start;
        for (int i = 0; i < ncyc; i++) begin
            if (!up_pend && tag_ctr < k_max_tags && int'($urandom_range(0, 99)) < k_in_pct) begin
                up_pend = 1; tag_ctr++; up_tag = tag_ctr;
            end
            in_valid  = up_pend;
            par_valid = '0;
            par_phv   = '0;
            for (int k = 0; k < N; k++)
                if (par_has[k]) par_phv[k*PW +: PW] = phv_of(par_tag[k]);
            cidx    = col_cnt % N;
            exp_stg = '0;
            if (par_has[cidx] && !m_ov) exp_stg[cidx] = 1'b1;
            if (exp_stg[cidx] && cyc >= done_cyc[cidx]) par_valid[cidx] = 1'b1;
            out_ready = (cyc >= k_ordy_low_until) && (int'($urandom_range(0, 99)) < k_ordy_pct);
            #1;
            didx      = acc_cnt % N;
            go        = up_pend && (cyc >= next_ok) && !par_has[didx];
            exp_start = go ? (N'(1) << didx) : '0;
            exp_ir    = (cyc == ack_due);
            chk("par_start", 64'(par_start), 64'(exp_start));
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            chk("stg_ready", 64'(par_stg_ready), 64'(exp_stg));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_phv", 64'(out_phv), 64'(m_phv));
            chk("err", 64'(err), 64'(0));
`ifdef PARSER_SCHED_STATS_EN
            chk("stat_pkts", 64'(stat_pkts), 64'(m_pkts));
            chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
            if (cyc >= next_ok && up_pend && par_has[didx]) m_stall++;
            if (exp_ir) m_pkts++;
            if (go) begin
                par_has[didx]  = 1;
                par_tag[didx]  = up_tag;
                done_cyc[didx] = cyc + int'($urandom_range(k_lat_lo[didx], k_lat_hi[didx]));
                ack_due = cyc + H + 1;
                next_ok = cyc + H + 2;
                acc_cnt++;
                exp_q.push_back(up_tag);
                start_log.push_back(cyc);
            end
            if (exp_ir) up_pend = 0;
            if (m_ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL order: drain with no accepted packet outstanding");
                end else begin
                    chk("order", 64'(out_phv), 64'(phv_of(exp_q.pop_front())));
                end
                m_ov = 0;
            end else if (par_valid[cidx]) begin
                m_ov  = 1;
                m_phv = phv_of(par_tag[cidx]);
                par_has[cidx] = 0;
                col_cnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // ---------------- directed single-packet vector table ----------------
    typedef struct {
        logic         iv;
        logic [N-1:0] pv;
        logic         ordy;
        logic [N-1:0] e_start;
        logic         e_ir;
        logic [N-1:0] e_stg;
        logic         e_ov;
        logic         e_err;
    } vec_t;

    vec_t tbl[8];
    localparam logic [PW-1:0] PHV_A5 = 64'hA5A5_0000_0000_00A5;

    initial begin
        tbl[0] = '{1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid  = tbl[i].iv;
            par_valid = tbl[i].pv;
            par_phv   = '0;
            par_phv[PW-1:0] = PHV_A5;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_start", i), 64'(par_start), 64'(tbl[i].e_start));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_stg", i), 64'(par_stg_ready), 64'(tbl[i].e_stg));
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].e_err));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_phv", i), 64'(out_phv), 64'(PHV_A5));
            @(posedge clk); #1;
        end
        // c_ptr has advanced to 1, so a PHV from parser 0 is now out of turn.
        par_valid = 2'b01;
        @(posedge clk); #1;
        par_valid = '0;
        chk("cptr_adv_err", 64'(err), 64'(1));
        chk("cptr_adv_out_valid", 64'(out_valid), 64'(0));

        // Out-of-turn PHV from parser 1 while c_ptr=0: sticky err, output untouched.
        do_reset();
        par_valid = 2'b10;
        par_phv   = {64'hDEAD_BEEF_0000_0001, 64'h0};
        @(posedge clk); #1;
        par_valid = '0;
        chk("inj_err", 64'(err), 64'(1));
        chk("inj_out_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("inj_err_sticky", 64'(err), 64'(1));
        chk("inj_out_phv", 64'(out_phv), 64'(0));

        // In-turn parser but never started (busy clear).
        do_reset();
        par_valid = 2'b01;
        @(posedge clk); #1;
        par_valid = '0;
        chk("notbusy_err", 64'(err), 64'(1));
        chk("notbusy_out_valid", 64'(out_valid), 64'(0));

        // Back-to-back 4 packets: starts at cycles 0,4,8,12 alternating parsers.
        do_reset();
        set_knobs(100, 100, 0, 4, 2, 2, 2, 2);
        run(40);
        chk("b2b_starts", 64'(start_log.size()), 64'(4));
        for (int i = 0; i < start_log.size() && i < 4; i++)
            chk($sformatf("b2b_start%0d_cyc", i), 64'(start_log[i]), 64'(4 * i));
        chk("b2b_collected", 64'(col_cnt), 64'(4));

        // Parser 1 finishes long before parser 0; order must still be tag1, tag2.
        do_reset();
        set_knobs(100, 100, 0, 2, 12, 12, 1, 1);
        run(40);
        chk("fast1_collected", 64'(col_cnt), 64'(2));
        chk("fast1_drained", 64'(exp_q.size()), 64'(0));

        // Stage 0 stalled for the first 25 cycles with both parsers done.
        do_reset();
        set_knobs(100, 100, 25, 2, 1, 1, 1, 1);
        run(22);
        chk("stall_held_valid", 64'(out_valid), 64'(1));
        chk("stall_held_stg", 64'(par_stg_ready), 64'(0));
        chk("stall_held_phv", 64'(out_phv), 64'(phv_of(1)));
        run(20);
        chk("stall_collected", 64'(col_cnt), 64'(2));

`ifdef PARSER_SCHED_STATS_EN
        // Parser 0 busy until cycle 14, so tag 3 waits at d_ptr=0 for cycles 8..14.
        do_reset();
        set_knobs(100, 100, 0, 3, 14, 14, 1, 1);
        run(40);
        chk("stats_pkts", 64'(stat_pkts), 64'(3));
        chk("stats_stall", 64'(stat_stall), 64'(7));
`endif

        // Randomized traffic, then a reset mid-flight and more traffic.
        do_reset();
        set_knobs(60, 70, 0, 32'hFFFF_FFFF, 1, 10, 1, 10);
        run(3000);
        do_reset();
        run(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
